// File: rtl/nn_pkg.sv
// Shared neuron-array definitions: output width and layer_argmax state encoding.
package nn_pkg;

   // Width of one ReLU neuron output
   localparam int unsigned DATA_W = 23;

   // Layer argmax controller states
   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_SCAN    = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

endpackage : nn_pkg

// File: rtl/max_compare.sv
// Combinational running-maximum step: keeps the current best unless the
// candidate is strictly greater (unsigned), so ties favour the lower index.
//   cand_i/cand_idx_i : candidate value and its neuron index
//   best_i/best_idx_i : current best value and its neuron index
//   new_best_o/new_idx_o : updated best value and index
module max_compare #(
   parameter int unsigned DATA_W = 23,
   parameter int unsigned IDX_W  = 2
) (
   input  logic [DATA_W-1:0] cand_i,
   input  logic [IDX_W-1:0]  cand_idx_i,
   input  logic [DATA_W-1:0] best_i,
   input  logic [IDX_W-1:0]  best_idx_i,
   output logic [DATA_W-1:0] new_best_o,
   output logic [IDX_W-1:0]  new_idx_o
);

   always_comb begin
      new_best_o = best_i;
      new_idx_o  = best_idx_i;
      if (cand_i > best_i) begin
         new_best_o = cand_i;
         new_idx_o  = cand_idx_i;
      end
   end

endmodule : max_compare

// File: rtl/layer_argmax.sv
// Buffers one ReLU output per neuron for a full layer, scans the buffer
// sequentially for the largest value and presents the winner (index + value)
// with a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous abort back to COLLECT (highest priority)
//   in_valid/in_data  : neuron output stream, in_ready high while collecting
//   out_valid/out_ready : result handshake
//   out_idx/out_max   : index and value of the layer maximum
module layer_argmax #(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned DATA_W      = nn_pkg::DATA_W,
   parameter int unsigned IDX_W       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_max
);

   import nn_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] buf_q [NUM_NEURONS];
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]  scan_ptr_q, scan_ptr_d;
   logic [DATA_W-1:0] best_q, best_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [DATA_W-1:0] out_max_q, out_max_d;

   logic              accept;
   logic              last_wr;
   logic              first_scan;
   logic              last_scan;
   logic [DATA_W-1:0] cmp_best;
   logic [IDX_W-1:0]  cmp_idx;

   assign accept     = in_valid & in_ready_q;
   assign last_wr    = (wr_ptr_q == LAST_IDX);
   // scan_ptr is parked at 0 outside SCAN, so 0 marks the load cycle
   assign first_scan = (scan_ptr_q == '0);
   assign last_scan  = (scan_ptr_q == LAST_IDX);

   max_compare #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_max_compare (
      .cand_i     (buf_q[scan_ptr_q]),
      .cand_idx_i (scan_ptr_q),
      .best_i     (best_q),
      .best_idx_i (best_idx_q),
      .new_best_o (cmp_best),
      .new_idx_o  (cmp_idx)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_COLLECT;
      end else begin
         case (state_q)
            ST_COLLECT: if (accept && last_wr)           state_d = ST_SCAN;
            ST_SCAN:    if (!first_scan && last_scan)    state_d = ST_HOLD;
            ST_HOLD:    if (out_valid_q && out_ready)    state_d = ST_COLLECT;
            default:                                     state_d = ST_COLLECT;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      scan_ptr_d  = scan_ptr_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_max_d   = out_max_q;
      if (flush) begin
         wr_ptr_d    = '0;
         scan_ptr_d  = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (accept) begin
                  wr_ptr_d = last_wr ? '0 : wr_ptr_q + IDX_W'(1);
               end
            end
            ST_SCAN: begin
               if (first_scan) begin
                  best_d     = buf_q[0];
                  best_idx_d = '0;
                  scan_ptr_d = IDX_W'(1);
               end else begin
                  best_d     = cmp_best;
                  best_idx_d = cmp_idx;
                  if (last_scan) begin
                     out_max_d   = cmp_best;
                     out_idx_d   = cmp_idx;
                     out_valid_d = 1'b1;
                     scan_ptr_d  = '0;
                  end else begin
                     scan_ptr_d = scan_ptr_q + IDX_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               wr_ptr_d   = '0;
               scan_ptr_d = '0;
            end
         endcase
      end
      // Registered so in_ready stays low through the handshake cycle
      in_ready_d = (state_d == ST_COLLECT);
   end

   // Control and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         scan_ptr_q  <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_max_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         scan_ptr_q  <= scan_ptr_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_max_q   <= out_max_d;
      end
   end

   // Layer buffer; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (accept && !flush) begin
         buf_q[wr_ptr_q] <= in_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_max   = out_max_q;

endmodule : layer_argmax

// File: tb/tb_layer_argmax.sv
// Self-checking bench for layer_argmax: scoreboard queue filled by the
// stimulus side, drained by an independent output monitor.
module tb_layer_argmax;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 23;
   localparam int unsigned IW = 2;

   typedef logic [DW-1:0] layer_t [N];
   typedef struct {
      logic [IW-1:0] idx;
      logic [DW-1:0] mx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;
   logic [DW-1:0] out_max;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_acc_cyc = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];

   layer_argmax #(
      .NUM_NEURONS (N),
      .DATA_W      (DW),
      .IDX_W       (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_max   (out_max)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: largest value, then the first neuron holding it
   function automatic exp_t model(input layer_t v);
      exp_t e;
      logic [DW-1:0] mx;
      mx = '0;
      foreach (v[i]) if (v[i] > mx) mx = v[i];
      e.mx  = mx;
      e.idx = '0;
      for (int i = N - 1; i >= 0; i--) if (v[i] == mx) e.idx = IW'(i);
      return e;
   endfunction

   task automatic push_val(input logic [DW-1:0] v);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 required 1");
      end
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic send_layer(input layer_t v, input bit expect_out);
      for (int i = 0; i < N; i++) push_val(v[i]);
      if (expect_out) exp_q.push_back(model(v));
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout: got 0 required 1");
      end
   endtask

   // Monitor: a handshake is taken at the next edge unless flush/rst intervene
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (out_valid && out_ready && !flush && !rst) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got idx=%0d max=%0h required none", out_idx, out_max);
            end else begin
               e = exp_q.pop_front();
               chk("result_idx", 32'(out_idx), 32'(e.idx));
               chk("result_max", 32'(out_max), 32'(e.mx));
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      layer_t l;
      logic [IW-1:0] h_idx;
      logic [DW-1:0] h_max;
      int n;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_in_ready",  32'(in_ready), 1);
      chk("reset_out_idx",   32'(out_idx), 0);
      chk("reset_out_max",   32'(out_max), 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic layer, latency and single-cycle valid
      out_ready = 1'b1;
      l = '{23'd5, 23'd900, 23'd12, 23'd3};
      send_layer(l, 1'b1);
      wait_valid();
      chk("latency", 32'(cyc - last_acc_cyc), 4);
      @(negedge clk);
      chk("valid_one_cycle", 32'(out_valid), 0);

      // Tie resolves to lowest index
      l = '{23'd7, 23'd20, 23'd20, 23'd1};
      send_layer(l, 1'b1);
      wait_valid();
      @(negedge clk);

      // All-zero layer
      l = '{23'd0, 23'd0, 23'd0, 23'd0};
      send_layer(l, 1'b1);
      wait_valid();
      chk("allzero_valid", 32'(out_valid), 1);
      @(negedge clk);

      // Backpressure: stable outputs, ignored inputs
      out_ready = 1'b0;
      l = '{23'd10, 23'd40, 23'd30, 23'd20};
      send_layer(l, 1'b1);
      wait_valid();
      h_idx = out_idx;
      h_max = out_max;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 23'h400000;
         chk("bp_idx_stable", 32'(out_idx), 32'(h_idx));
         chk("bp_max_stable", 32'(out_max), 32'(h_max));
         chk("bp_valid_held", 32'(out_valid), 1);
         chk("bp_in_ready_low", 32'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("hs_in_ready_low", 32'(in_ready), 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("after_hs_valid", 32'(out_valid), 0);
      chk("after_hs_in_ready", 32'(in_ready), 1);
      l = '{23'd1, 23'd2, 23'd3, 23'h7FFFFF};
      send_layer(l, 1'b1);
      wait_valid();
      @(negedge clk);

      // Flush a partial layer
      push_val(23'd50);
      push_val(23'd60);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      l = '{23'd9, 23'd1, 23'd1, 23'd1};
      send_layer(l, 1'b1);
      wait_valid();
      @(negedge clk);

      // Flush in HOLD beats a simultaneous handshake
      out_ready = 1'b0;
      l = '{23'd3, 23'd4, 23'd5, 23'd6};
      send_layer(l, 1'b0);
      wait_valid();
      out_ready = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_hold_valid", 32'(out_valid), 0);
      chk("flush_hold_in_ready", 32'(in_ready), 1);

      // Async reset mid-SCAN
      l = '{23'd100, 23'd5, 23'd6, 23'd7};
      send_layer(l, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_scan_valid", 32'(out_valid), 0);
      chk("rst_scan_in_ready", 32'(in_ready), 1);
      chk("rst_scan_idx", 32'(out_idx), 0);
      chk("rst_scan_max", 32'(out_max), 0);
      @(negedge clk);
      rst = 1'b0;

      // Async reset mid-HOLD
      out_ready = 1'b0;
      l = '{23'd1, 23'd9, 23'd2, 23'd3};
      send_layer(l, 1'b0);
      wait_valid();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_hold_valid", 32'(out_valid), 0);
      chk("rst_hold_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      l = '{23'd8, 23'd3, 23'd8, 23'd2};
      send_layer(l, 1'b1);
      wait_valid();
      @(negedge clk);

      // Randomized layers with random backpressure
      rand_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         for (int i = 0; i < N; i++) begin
            case (mode)
               0:       l[i] = DW'($urandom);
               1:       l[i] = DW'($urandom_range(0, 3));
               default: l[i] = ($urandom_range(0, 1) != 0) ? 23'h7FFFFF : 23'd0;
            endcase
         end
         send_layer(l, 1'b1);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      rand_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_layer_argmax
